tt_um_uart_spi_top: RTL and testbench
=====================================

// Module: tt_um_uart_spi_top
// PURPOSE
//  Tiny Tapeout top: independent UART (8N1) and SPI master (16-bit, CPOL=1) sharing one clock.
//  Loopback mode re-transmits the last received UART byte / SPI word for board bring-up.
//  Bit rates come from a 2-bit frequency select on ui_in[1:0].
// PARAMETERS
//  CNT_W     13  width of UART/SPI timing counters (holds max UART divisor 5208)
//  SPI_BITS  16  SPI word length, MSB first
// PORTS
//  clk      in   1  system clock (50 MHz nominal)
//  rst      in   1  synchronous, active-high reset
//  ena      in   1  always 1; ignored
//  ui_in    in   8  [1:0] freq_sel, [2] uart_rx, [3] uart_tx_start, [4] cs_bar (active low),
//                   [5] mosi, [6] unused, [7] loopback
//  uio_in   in   8  [0] spi_rx_start, [1] spi_tx_start, [7:2] tx_data_ext
//  uo_out   out  8  [0] uart_tx, [1] miso_out, [2] uart_rx_valid, [3] uart_tx_done,
//                   [4] spi_rx_valid, [5] spi_tx_done, [6] sclk, [7] spi_busy (see CONFIGURATION)
//  uio_out  out  8  constant 0
//  uio_oe   out  8  constant 0 (all uio are inputs)
// BEHAVIOUR
//  Reset: uo_out=8'b0100_0001 (tx idle high, sclk idle high, all flags 0); both FSMs IDLE; rx regs 0.
//  Timing (sampled per transaction start): freq_sel 00/01/10/11 -> UART N=5208/434/50/25 clk per bit;
//   SPI half-period H=8/1/2/4 clk.
//  UART RX: uart_rx via 2-FF sync. IDLE->START on low; at N/2 recheck low else IDLE.
//   DATA: 8 samples, N apart, LSB first. STOP: sample at +N.
//   Then byte -> rx_reg; uart_rx_valid=1 next cycle. Valid is sticky; cleared on next start-bit detect.
//  UART TX: in IDLE, uart_tx_start=1 latches byte = loopback ? rx_reg : {2'b00,tx_data_ext};
//   uart_tx_done cleared. Start bit on next cycle; start, 8 data LSB first, stop, each N cycles.
//   uart_tx_done=1 (sticky) after stop bit. Start ignored while busy; held start retransmits.
//  SPI: start accepted only in IDLE with cs_bar=0; cs_bar=1 -> start ignored, sclk stays high.
//   spi_rx_start / spi_tx_start pulse; both in same cycle = one full-duplex transfer setting both flags.
//   Transfer: 16 sclk cycles, each H low then H high. First falling edge H cycles after start.
//   miso_out changes on falling edges, MSB first. mosi sampled on rising edges.
//   TX word latched at start = loopback ? spi_rx_reg : {10'b0,tx_data_ext}.
//   miso_out=0 outside TX transfers. spi_busy=1 from start until done.
//   One cycle after 16th rising edge: RX word -> spi_rx_reg, spi_rx_valid=1 (RX transfer);
//   spi_tx_done=1 (TX transfer). Flags sticky; cleared when the matching start is accepted.
//   sclk stays high after the 16th rising edge.
//  UART and SPI run concurrently, no interaction. Changing freq_sel mid-transfer has no effect.
//  rst mid-operation: next cycle all FSMs IDLE, outputs at reset values.
// CONFIGURATION
//  UART_FRAME_ERR_EN defined: stop bit must be 1.
//   If 0: byte discarded, rx_valid stays 0, uo_out[7] = frame_err (sticky, cleared on next start bit).
//   spi_busy not brought out.
//  Not defined: stop bit not checked; byte always accepted; uo_out[7]=spi_busy.
// TESTING
//  1 rst=1 two cycles -> uo_out=8'h41, uio_oe=8'h00, uio_out=8'h00.
//  2 freq_sel=10, loopback=1, serial 8'hA5 on ui_in[2] at 1000 ns/bit -> uo_out[2]=1;
//    pulse ui_in[3] -> uo_out[0] frame 0,1,0,1,0,0,1,0,1,1 at 50 clk/bit; uo_out[3]=1.
//  3 cs_bar=1, pulse spi_rx_start -> sclk high for 100 cycles, uo_out[4]=0, uo_out[5]=0.
//  4 cs_bar=0, freq_sel=10, pulse spi_rx_start, mosi 16'hA55A MSB first, driven on sclk falling edges
//    -> exactly 16 rising edges, uo_out[4]=1; then pulse spi_tx_start
//    -> miso sampled on rising edges = 16'hA55A, uo_out[5]=1.
//  5 rst mid UART TX -> uo_out[0]=1 and uo_out[3:2]=0 next cycle; new TX then runs normally.
//  6 UART_FRAME_ERR_EN: byte 8'h3C with stop=0 -> uo_out[2]=0, uo_out[7]=1; good byte clears uo_out[7].

Source files
------------

// File: rtl/tt_um_uart_spi_top.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_uart_spi_top
// Purpose  : Tiny Tapeout top with an independent 8N1 UART (RX + TX) and a
//            16-bit CPOL=1 SPI master sharing one clock. Loopback re-sends
//            the last received UART byte / SPI word. Bit rates are picked by
//            a 2-bit frequency select sampled at each transaction start.
// Options  : UART_FRAME_ERR_EN - check the stop bit, drop bad bytes and show
//            a sticky frame-error flag on uo_out[7] instead of spi_busy.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_uart_spi_top #(
  parameter int CNT_W    = 13,
  parameter int SPI_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BIT_W = $clog2(SPI_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [2:0] {SPI_IDLE = 3'd0, SPI_LEAD = 3'd1, SPI_LOW = 3'd2,
                            SPI_HIGH = 3'd3, SPI_FIN = 3'd4} spi_state_t;

  // Clocks per UART bit for each frequency select
  function automatic logic [CNT_W-1:0] uart_div(input logic [1:0] fs);
    case (fs)
      2'b00:   uart_div = CNT_W'(5208);
      2'b01:   uart_div = CNT_W'(434);
      2'b10:   uart_div = CNT_W'(50);
      default: uart_div = CNT_W'(25);
    endcase
  endfunction

  // Clocks per SPI half-period for each frequency select
  function automatic logic [CNT_W-1:0] spi_half(input logic [1:0] fs);
    case (fs)
      2'b00:   spi_half = CNT_W'(8);
      2'b01:   spi_half = CNT_W'(1);
      2'b10:   spi_half = CNT_W'(2);
      default: spi_half = CNT_W'(4);
    endcase
  endfunction

  // Input field aliases
  logic [1:0] freq_sel;
  logic       uart_rx, uart_tx_start, cs_bar, mosi, loopback;
  logic       spi_rx_start, spi_tx_start;
  logic [5:0] tx_data_ext;
  assign freq_sel      = ui_in[1:0];
  assign uart_rx       = ui_in[2];
  assign uart_tx_start = ui_in[3];
  assign cs_bar        = ui_in[4];
  assign mosi          = ui_in[5];
  assign loopback      = ui_in[7];
  assign spi_rx_start  = uio_in[0];
  assign spi_tx_start  = uio_in[1];
  assign tx_data_ext   = uio_in[7:2];

  // ---------------- UART RX ----------------
  logic            rx_meta_q, rx_sync_q, rx_hist_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d, rx_reg_q, rx_reg_d;
  logic            rx_valid_q, rx_valid_d;
`ifdef UART_FRAME_ERR_EN
  logic            frame_err_q, frame_err_d;
`endif

  // RX: start on a falling edge of the synced line, mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_reg_d   = rx_reg_q;
    rx_valid_d = rx_valid_q;
`ifdef UART_FRAME_ERR_EN
    frame_err_d = frame_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        // Edge (not level) detect so a low stop bit cannot fake a new start
        if (rx_hist_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_div_d   = uart_div(freq_sel);
          rx_valid_d = 1'b0;
`ifdef UART_FRAME_ERR_EN
          frame_err_d = 1'b0;
`endif
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - CNT_ONE) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q - CNT_ONE) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin // RX_STOP
        if (rx_cnt_q == rx_div_q - CNT_ONE) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
`ifdef UART_FRAME_ERR_EN
          if (rx_sync_q) begin
            rx_reg_d   = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
`else
          rx_reg_d   = rx_shift_q;
          rx_valid_d = 1'b1;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // RX registers and input synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_hist_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_reg_q   <= '0;
      rx_valid_q <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_hist_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_reg_q   <= rx_reg_d;
      rx_valid_q <= rx_valid_d;
`ifdef UART_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  // ---------------- UART TX ----------------
  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d, tx_done_q, tx_done_d;

  // TX: start, 8 data bits LSB first, stop; line driven from a flop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (uart_tx_start) begin
          tx_state_d = TX_START;
          tx_shift_d = loopback ? rx_reg_q : {2'b00, tx_data_ext};
          tx_div_d   = uart_div(freq_sel);
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_done_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == tx_div_q - CNT_ONE) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == tx_div_q - CNT_ONE) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin // TX_STOP
        if (tx_cnt_q == tx_div_q - CNT_ONE) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // TX registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // ---------------- SPI master ----------------
  spi_state_t          spi_state_q, spi_state_d;
  logic [CNT_W-1:0]    spi_cnt_q, spi_cnt_d, spi_half_q, spi_half_d;
  logic [BIT_W-1:0]    spi_bit_q, spi_bit_d;
  logic [SPI_BITS-1:0] spi_tx_sh_q, spi_tx_sh_d, spi_rx_sh_q, spi_rx_sh_d;
  logic [SPI_BITS-1:0] spi_rx_reg_q, spi_rx_reg_d;
  logic                spi_is_rx_q, spi_is_rx_d, spi_is_tx_q, spi_is_tx_d;
  logic                sclk_q, sclk_d, miso_q, miso_d;
  logic                spi_rx_valid_q, spi_rx_valid_d, spi_tx_done_q, spi_tx_done_d;
  logic                spi_busy;

  assign spi_busy = (spi_state_q != SPI_IDLE);

  // SPI: idle-high lead-in, then SPI_BITS low/high sclk periods, then flags
  always_comb begin
    spi_state_d    = spi_state_q;
    spi_cnt_d      = spi_cnt_q;
    spi_half_d     = spi_half_q;
    spi_bit_d      = spi_bit_q;
    spi_tx_sh_d    = spi_tx_sh_q;
    spi_rx_sh_d    = spi_rx_sh_q;
    spi_rx_reg_d   = spi_rx_reg_q;
    spi_is_rx_d    = spi_is_rx_q;
    spi_is_tx_d    = spi_is_tx_q;
    sclk_d         = sclk_q;
    miso_d         = miso_q;
    spi_rx_valid_d = spi_rx_valid_q;
    spi_tx_done_d  = spi_tx_done_q;
    case (spi_state_q)
      SPI_IDLE: begin
        sclk_d = 1'b1;
        miso_d = 1'b0;
        if (!cs_bar && (spi_rx_start || spi_tx_start)) begin
          spi_state_d = SPI_LEAD;
          spi_cnt_d   = '0;
          spi_bit_d   = '0;
          spi_half_d  = spi_half(freq_sel);
          spi_is_rx_d = spi_rx_start;
          spi_is_tx_d = spi_tx_start;
          spi_tx_sh_d = loopback ? spi_rx_reg_q : SPI_BITS'(tx_data_ext);
          if (spi_rx_start) spi_rx_valid_d = 1'b0;
          if (spi_tx_start) spi_tx_done_d  = 1'b0;
        end
      end
      SPI_LEAD: begin
        if (spi_cnt_q == spi_half_q - CNT_ONE) begin
          spi_cnt_d   = '0;
          sclk_d      = 1'b0;
          miso_d      = spi_is_tx_q & spi_tx_sh_q[SPI_BITS-1];
          spi_state_d = SPI_LOW;
        end else begin
          spi_cnt_d = spi_cnt_q + CNT_ONE;
        end
      end
      SPI_LOW: begin
        if (spi_cnt_q == spi_half_q - CNT_ONE) begin
          spi_cnt_d   = '0;
          sclk_d      = 1'b1;
          spi_rx_sh_d = {spi_rx_sh_q[SPI_BITS-2:0], mosi};
          spi_state_d = (spi_bit_q == BIT_W'(SPI_BITS - 1)) ? SPI_FIN : SPI_HIGH;
        end else begin
          spi_cnt_d = spi_cnt_q + CNT_ONE;
        end
      end
      SPI_HIGH: begin
        if (spi_cnt_q == spi_half_q - CNT_ONE) begin
          spi_cnt_d   = '0;
          sclk_d      = 1'b0;
          spi_bit_d   = spi_bit_q + BIT_W'(1);
          spi_tx_sh_d = spi_tx_sh_q << 1;
          miso_d      = spi_is_tx_q & spi_tx_sh_q[SPI_BITS-2];
          spi_state_d = SPI_LOW;
        end else begin
          spi_cnt_d = spi_cnt_q + CNT_ONE;
        end
      end
      default: begin // SPI_FIN: one cycle after the last rising edge
        spi_state_d = SPI_IDLE;
        miso_d      = 1'b0;
        if (spi_is_rx_q) begin
          spi_rx_reg_d   = spi_rx_sh_q;
          spi_rx_valid_d = 1'b1;
        end
        if (spi_is_tx_q) spi_tx_done_d = 1'b1;
      end
    endcase
  end

  // SPI registers
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_state_q    <= SPI_IDLE;
      spi_cnt_q      <= '0;
      spi_half_q     <= '0;
      spi_bit_q      <= '0;
      spi_tx_sh_q    <= '0;
      spi_rx_sh_q    <= '0;
      spi_rx_reg_q   <= '0;
      spi_is_rx_q    <= 1'b0;
      spi_is_tx_q    <= 1'b0;
      sclk_q         <= 1'b1;
      miso_q         <= 1'b0;
      spi_rx_valid_q <= 1'b0;
      spi_tx_done_q  <= 1'b0;
    end else begin
      spi_state_q    <= spi_state_d;
      spi_cnt_q      <= spi_cnt_d;
      spi_half_q     <= spi_half_d;
      spi_bit_q      <= spi_bit_d;
      spi_tx_sh_q    <= spi_tx_sh_d;
      spi_rx_sh_q    <= spi_rx_sh_d;
      spi_rx_reg_q   <= spi_rx_reg_d;
      spi_is_rx_q    <= spi_is_rx_d;
      spi_is_tx_q    <= spi_is_tx_d;
      sclk_q         <= sclk_d;
      miso_q         <= miso_d;
      spi_rx_valid_q <= spi_rx_valid_d;
      spi_tx_done_q  <= spi_tx_done_d;
    end
  end

  // ---------------- Output mapping ----------------
  logic bit7;
  logic unused_inputs;
`ifdef UART_FRAME_ERR_EN
  assign bit7          = frame_err_q;
  assign unused_inputs = &{1'b0, ena, ui_in[6], spi_busy};
`else
  assign bit7          = spi_busy;
  assign unused_inputs = &{1'b0, ena, ui_in[6]};
`endif

  assign uo_out  = {bit7, sclk_q, spi_tx_done_q, spi_rx_valid_q,
                    tx_done_q, rx_valid_q, miso_q, tx_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_uart_spi_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_uart_spi_top
// Purpose  : Self-checking bench for tt_um_uart_spi_top. Expected UART bytes
//            and SPI words are queued when stimulus is applied and compared
//            when the serial output is captured.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_uart_spi_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena = 1'b1;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  logic [1:0] freq_sel;
  logic       uart_rx, uart_tx_start, cs_bar, mosi, loopback;
  logic       spi_rx_start, spi_tx_start;
  logic [5:0] tx_data_ext;

  assign ui_in  = {loopback, 1'b0, mosi, cs_bar, uart_tx_start, uart_rx, freq_sel};
  assign uio_in = {tx_data_ext, spi_tx_start, spi_rx_start};

  always #10 clk = ~clk;

  tt_um_uart_spi_top dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int n_checks = 0;
  int n_bad    = 0;
  logic [7:0]  uart_q[$];
  logic [15:0] spi_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Serial byte into uart_rx at 50 clocks per bit
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (50) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (50) @(negedge clk);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic uart_tx_pulse();
    uart_tx_start = 1'b1;
    @(negedge clk);
    uart_tx_start = 1'b0;
    check_val("tx_done_clr", {31'd0, uo_out[3]}, 32'd0);
  endtask

  // Capture one frame mid-bit from uo_out[0] and compare to the scoreboard
  task automatic uart_capture(input string tag);
    logic [9:0] fr;
    logic [7:0] e;
    int t;
    t = 0;
    while (uo_out[0] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check_val({tag, "_start_timeout"}, 32'd1, 32'd0);
      return;
    end
    repeat (25) @(negedge clk);
    fr[0] = uo_out[0];
    for (int i = 1; i < 10; i++) begin
      repeat (50) @(negedge clk);
      fr[i] = uo_out[0];
    end
    repeat (26) @(negedge clk);
    check_val({tag, "_done"}, {31'd0, uo_out[3]}, 32'd1);
    if (uart_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = uart_q.pop_front();
      check_val({tag, "_frame"}, {22'd0, fr}, {22'd0, 1'b1, e, 1'b0});
    end
  endtask

  // One SPI transfer: drive mosi on sclk falls, sample miso on sclk rises
  task automatic spi_run(input logic rxs, input logic txs, input logic [15:0] mw, input string tag);
    logic [15:0] got;
    logic [15:0] e;
    logic prev;
    int rises;
    int falls;
    int t;
    got = '0;
    rises = 0;
    t = 0;
    spi_rx_start = rxs;
    spi_tx_start = txs;
    @(negedge clk);
    spi_rx_start = 1'b0;
    spi_tx_start = 1'b0;
    if (rxs) check_val({tag, "_rxv_clr"}, {31'd0, uo_out[4]}, 32'd0);
    if (txs) check_val({tag, "_txd_clr"}, {31'd0, uo_out[5]}, 32'd0);
`ifndef UART_FRAME_ERR_EN
    check_val({tag, "_busy"}, {31'd0, uo_out[7]}, 32'd1);
`endif
    prev = uo_out[6];
    while (rises < 16 && t < 400) begin
      @(negedge clk);
      t++;
      if (prev && !uo_out[6]) mosi = mw[15-rises];
      if (!prev && uo_out[6]) begin
        got = {got[14:0], uo_out[1]};
        rises++;
      end
      prev = uo_out[6];
    end
    check_val({tag, "_rises"}, rises, 32'd16);
    if (rises < 16) return;
    @(negedge clk);
    if (rxs) check_val({tag, "_rxv"}, {31'd0, uo_out[4]}, 32'd1);
    if (txs) begin
      check_val({tag, "_txd"}, {31'd0, uo_out[5]}, 32'd1);
      if (spi_q.size() == 0) begin
        check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = spi_q.pop_front();
        check_val({tag, "_miso"}, {16'd0, got}, {16'd0, e});
      end
    end
    check_val({tag, "_miso_idle"}, {31'd0, uo_out[1]}, 32'd0);
`ifndef UART_FRAME_ERR_EN
    check_val({tag, "_busy_off"}, {31'd0, uo_out[7]}, 32'd0);
`endif
    falls = 0;
    prev = uo_out[6];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prev && !uo_out[6]) falls++;
      prev = uo_out[6];
    end
    check_val({tag, "_extra_edges"}, falls, 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    rst = 1'b1;
    freq_sel = 2'b10;
    uart_rx = 1'b1;
    uart_tx_start = 1'b0;
    cs_bar = 1'b1;
    mosi = 1'b0;
    loopback = 1'b0;
    spi_rx_start = 1'b0;
    spi_tx_start = 1'b0;
    tx_data_ext = 6'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_uo_out", {24'd0, uo_out}, 32'h41);
    check_val("rst_uio_oe", {24'd0, uio_oe}, 32'h00);
    check_val("rst_uio_out", {24'd0, uio_out}, 32'h00);
    rst = 1'b0;
    @(negedge clk);

    // SPI start ignored while cs_bar is high
    spi_rx_start = 1'b1;
    @(negedge clk);
    spi_rx_start = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!uo_out[6]) lows++;
    end
    check_val("cs_hi_sclk_lows", lows, 32'd0);
    check_val("cs_hi_rxv", {31'd0, uo_out[4]}, 32'd0);
    check_val("cs_hi_txd", {31'd0, uo_out[5]}, 32'd0);

    // SPI receive, transmit via loopback, full duplex, external data
    cs_bar = 1'b0;
    loopback = 1'b1;
    spi_run(1'b1, 1'b0, 16'hA55A, "spi_rx");
    spi_q.push_back(16'hA55A);
    spi_run(1'b0, 1'b1, 16'h0000, "spi_tx");
    freq_sel = 2'b01;
    spi_q.push_back(16'hA55A);
    spi_run(1'b1, 1'b1, 16'h1234, "spi_fd");
    freq_sel = 2'b11;
    spi_q.push_back(16'h1234);
    spi_run(1'b0, 1'b1, 16'h0000, "spi_tx2");
    freq_sel = 2'b10;
    loopback = 1'b0;
    tx_data_ext = 6'h2D;
    spi_q.push_back(16'h002D);
    spi_run(1'b0, 1'b1, 16'hFFFF, "spi_ext");
    cs_bar = 1'b1;

    // UART receive then loopback transmit
    loopback = 1'b1;
    uart_send(8'hA5, 1'b1);
    check_val("urx_valid_a5", {31'd0, uo_out[2]}, 32'd1);
    uart_q.push_back(8'hA5);
    uart_tx_pulse();
    uart_capture("utx_a5");
    uart_send(8'h3C, 1'b1);
    check_val("urx_valid_3c", {31'd0, uo_out[2]}, 32'd1);
    uart_q.push_back(8'h3C);
    uart_tx_pulse();
    uart_capture("utx_3c");
    loopback = 1'b0;
    tx_data_ext = 6'h2B;
    uart_q.push_back(8'h2B);
    uart_tx_pulse();
    uart_capture("utx_ext");

    // Reset in the middle of a UART transmit
    tx_data_ext = 6'h15;
    uart_tx_start = 1'b1;
    @(negedge clk);
    uart_tx_start = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_uo_out", {24'd0, uo_out}, 32'h41);
    rst = 1'b0;
    @(negedge clk);
    tx_data_ext = 6'h2A;
    uart_q.push_back(8'h2A);
    uart_tx_pulse();
    uart_capture("utx_after_rst");

    // Stop bit low
    loopback = 1'b1;
`ifdef UART_FRAME_ERR_EN
    uart_send(8'h3C, 1'b0);
    check_val("ferr_valid", {31'd0, uo_out[2]}, 32'd0);
    check_val("ferr_flag", {31'd0, uo_out[7]}, 32'd1);
    uart_send(8'h81, 1'b1);
    check_val("ferr_clr", {31'd0, uo_out[7]}, 32'd0);
    check_val("ferr_good_valid", {31'd0, uo_out[2]}, 32'd1);
    uart_q.push_back(8'h81);
`else
    uart_send(8'hC3, 1'b0);
    check_val("nostop_valid", {31'd0, uo_out[2]}, 32'd1);
    check_val("nostop_busy", {31'd0, uo_out[7]}, 32'd0);
    uart_q.push_back(8'hC3);
`endif
    uart_tx_pulse();
    uart_capture("utx_last");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
